// File: rtl/seg_pkg.sv
// Shared constants for the six-digit seven-segment scanner: active-low
// segment codes with the dp bit set (dp off), and the digit-select idle value.
package seg_pkg;

  localparam int DIGITS = 6;

  typedef logic [2:0] dig_idx_t;

  localparam dig_idx_t LAST_DIG = dig_idx_t'(DIGITS - 1);

  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_2    = 8'hA4;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_4    = 8'h99;
  localparam logic [7:0] SEG_5    = 8'h92;
  localparam logic [7:0] SEG_6    = 8'h82;
  localparam logic [7:0] SEG_7    = 8'hF8;
  localparam logic [7:0] SEG_8    = 8'h80;
  localparam logic [7:0] SEG_9    = 8'h90;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  localparam logic [5:0] SEL_OFF  = 6'h3F;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low a..g pattern; any non-decimal
// nibble shows a lone dash so corrupt counter values are visible.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH[6:0];
    case (bcd_i)
      4'd0:    seg_o = SEG_0[6:0];
      4'd1:    seg_o = SEG_1[6:0];
      4'd2:    seg_o = SEG_2[6:0];
      4'd3:    seg_o = SEG_3[6:0];
      4'd4:    seg_o = SEG_4[6:0];
      4'd5:    seg_o = SEG_5[6:0];
      4'd6:    seg_o = SEG_6[6:0];
      4'd7:    seg_o = SEG_7[6:0];
      4'd8:    seg_o = SEG_8[6:0];
      4'd9:    seg_o = SEG_9[6:0];
      default: seg_o = SEG_DASH[6:0];
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Six-digit multiplexed display scanner: per-frame snapshot, leading-zero
// blanking on the upper three digits, decimal points and a dark ghost interval.
module seg_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int GHOST_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] disp_num,
  input  logic [5:0]  dp_mask,
  input  logic        blank_lz,
  input  logic        disp_en,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GHOST_END = CNT_W'(GHOST_CYC);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  dig_idx_t         dig_idx_q, dig_idx_d;
  logic [23:0]      snap_num_q, snap_num_d;
  logic [5:0]       snap_dp_q, snap_dp_d;
  logic [5:0]       sel_q, sel_d;
  logic [7:0]       seg_q, seg_d;

  logic             slot_end;
  logic [3:0]       digit;
  logic [6:0]       seg7;
  logic             zero5, zero4, zero3;
  logic             blanked;

  bcd_to_seg u_dec (
    .bcd_i (digit),
    .seg_o (seg7)
  );

  // Inputs are only sampled at the very end of digit 5 so a frame never tears.
  always_comb begin
    slot_end   = (div_cnt_q == LAST_CNT);
    div_cnt_d  = slot_end ? '0 : div_cnt_q + CNT_W'(1);
    dig_idx_d  = dig_idx_q;
    snap_num_d = snap_num_q;
    snap_dp_d  = snap_dp_q;
    if (slot_end) begin
      dig_idx_d = (dig_idx_q == LAST_DIG) ? '0 : dig_idx_q + 3'd1;
      if (dig_idx_q == LAST_DIG) begin
        snap_num_d = disp_num;
        snap_dp_d  = dp_mask;
      end
    end
  end

  always_comb begin
    digit   = snap_num_q[{dig_idx_q, 2'b00} +: 4];
    zero5   = (snap_num_q[23:20] == 4'd0);
    zero4   = zero5 && (snap_num_q[19:16] == 4'd0);
    zero3   = zero4 && (snap_num_q[15:12] == 4'd0);
    blanked = blank_lz && (((dig_idx_q == 3'd5) && zero5) ||
                           ((dig_idx_q == 3'd4) && zero4) ||
                           ((dig_idx_q == 3'd3) && zero3));
    sel_d = SEL_OFF;
    seg_d = SEG_OFF;
    if (disp_en && (div_cnt_q >= GHOST_END) && !blanked) begin
      sel_d = ~(6'b000001 << dig_idx_q);
      seg_d = {~snap_dp_q[dig_idx_q], seg7};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      dig_idx_q  <= '0;
      snap_num_q <= '0;
      snap_dp_q  <= '0;
      sel_q      <= SEL_OFF;
      seg_q      <= SEG_OFF;
    end else begin
      div_cnt_q  <= div_cnt_d;
      dig_idx_q  <= dig_idx_d;
      snap_num_q <= snap_num_d;
      snap_dp_q  <= snap_dp_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: a cycle-position model derived from elapsed cycles
// predicts sel/seg every clock; directed scenarios plus randomized frames.
module tb_seg_scan;

  localparam int SCAN_DIV  = 4;
  localparam int GHOST_CYC = 1;
  localparam int FRAME     = 6 * SCAN_DIV;

  logic        clk;
  logic        rst_n;
  logic [23:0] disp_num;
  logic [5:0]  dp_mask;
  logic        blank_lz;
  logic        disp_en;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int          total;
  int          bad;
  int          p;
  logic [23:0] snapNum;
  logic [5:0]  snapDp;
  logic [7:0]  segTab [10];

  seg_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .GHOST_CYC (GHOST_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .disp_num (disp_num),
    .dp_mask  (dp_mask),
    .blank_lz (blank_lz),
    .disp_en  (disp_en),
    .sel      (sel),
    .seg      (seg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input logic [5:0] expSel, input logic [7:0] expSeg);
    total++;
    assert (sel === expSel) else begin
      bad++;
      $error("[TB] FAIL sel t=%0t got=%h expected=%h", $time, sel, expSel);
    end
    total++;
    assert (seg === expSeg) else begin
      bad++;
      $error("[TB] FAIL seg t=%0t got=%h expected=%h", $time, seg, expSeg);
    end
  endtask

  // p counts clocks since reset release; position and slot follow arithmetically.
  task automatic stepCycle();
    logic [5:0] expSel;
    logic [7:0] expSeg;
    logic [3:0] d;
    int         pos;
    int         slot;
    logic       dark;
    if (!rst_n) begin
      expSel  = 6'h3F;
      expSeg  = 8'hFF;
      p       = 0;
      snapNum = '0;
      snapDp  = '0;
    end else begin
      pos  = p % SCAN_DIV;
      slot = (p / SCAN_DIV) % 6;
      d    = 4'(snapNum >> (4 * slot));
      dark = !disp_en || (pos < GHOST_CYC) ||
             (blank_lz && slot >= 3 && (snapNum >> (4 * slot)) == 0);
      if (dark) begin
        expSel = 6'h3F;
        expSeg = 8'hFF;
      end else begin
        expSel = 6'h3F & ~(6'(1) << slot);
        expSeg = (d < 10) ? segTab[d] : 8'hBF;
        if (snapDp[slot]) expSeg[7] = 1'b0;
      end
      if (p % FRAME == FRAME - 1) begin
        snapNum = disp_num;
        snapDp  = dp_mask;
      end
      p++;
    end
    @(posedge clk);
    #1;
    checkOutput(expSel, expSeg);
  endtask

  task automatic applyStimulus(input logic [23:0] num, input logic [5:0] dp,
                               input logic lz, input logic en, input int cycles);
    disp_num = num;
    dp_mask  = dp;
    blank_lz = lz;
    disp_en  = en;
    for (int i = 0; i < cycles; i++) stepCycle();
  endtask

  // Runs until the model is in the lit part of the requested slot (bounded).
  task automatic runToSlot(input int want);
    int n;
    n = 0;
    while (!(((p / SCAN_DIV) % 6 == want) && (p % SCAN_DIV >= GHOST_CYC)) && n < 2 * FRAME) begin
      stepCycle();
      n++;
    end
    total++;
    assert (n < 2 * FRAME) else begin
      bad++;
      $error("[TB] FAIL slot_wait got=%0d expected<%0d", n, 2 * FRAME);
    end
  endtask

  initial begin
    segTab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    total = 0;
    bad   = 0;
    p     = 0;
    snapNum = '0;
    snapDp  = '0;
    rst_n    = 1'b0;
    disp_num = 24'h123456;
    dp_mask  = '0;
    blank_lz = 1'b0;
    disp_en  = 1'b1;

    $display("[TB] reset and scan order");
    applyStimulus(24'h123456, 6'h00, 1'b0, 1'b1, 3);
    rst_n = 1'b1;
    applyStimulus(24'h123456, 6'h00, 1'b0, 1'b1, 3 * FRAME);

    $display("[TB] snapshot / no tearing");
    applyStimulus(24'h111111, 6'h00, 1'b0, 1'b1, FRAME);
    runToSlot(2);
    applyStimulus(24'h222222, 6'h00, 1'b0, 1'b1, 2 * FRAME);

    $display("[TB] leading-zero blanking");
    applyStimulus(24'h000105, 6'h00, 1'b1, 1'b1, 2 * FRAME);
    applyStimulus(24'h000000, 6'h3F, 1'b1, 1'b1, 2 * FRAME);
    applyStimulus(24'h000000, 6'h00, 1'b0, 1'b1, 2 * FRAME);

    $display("[TB] decimal point and dash");
    applyStimulus(24'h98750C, 6'b000100, 1'b0, 1'b1, 2 * FRAME);
    applyStimulus(24'hFA0B00, 6'b100001, 1'b1, 1'b1, 2 * FRAME);

    $display("[TB] enable gating");
    applyStimulus(24'h654321, 6'h00, 1'b0, 1'b1, FRAME);
    applyStimulus(24'h654321, 6'h00, 1'b0, 1'b0, FRAME + 3);
    applyStimulus(24'h654321, 6'h00, 1'b0, 1'b1, FRAME);

    $display("[TB] reset mid-frame");
    runToSlot(3);
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    applyStimulus(24'h987654, 6'h01, 1'b0, 1'b1, 2 * FRAME);

    $display("[TB] randomized frames");
    for (int f = 0; f < 12; f++) begin
      disp_num = 24'($urandom) >> (4 * $urandom_range(0, 5));
      dp_mask  = 6'($urandom);
      blank_lz = 1'($urandom);
      for (int c = 0; c < FRAME; c++) begin
        disp_en = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) disp_num = 24'($urandom);
        stepCycle();
      end
    end
    disp_en = 1'b1;
    applyStimulus(24'h000070, 6'h00, 1'b1, 1'b1, 2 * FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
